sw_debounce: RTL and testbench

Input conditioner for the board slide switches. Synchronises each raw switch line into `clk`, debounces it with a per-bit stability counter, and presents a clean switch word plus single-cycle rise/fall event pulses. Sits directly upstream of the switch peripheral: `sw_db` drives that peripheral's `sw` input, so the CPU only ever reads glitch-free, metastability-safe values.

---
 rtl/sw_debounce_pkg.sv | 12 +
 rtl/sw_debounce_bit.sv | 64 ++++++
 rtl/sw_debounce.sv | 46 ++++
 tb/tb_sw_debounce.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/sw_debounce_pkg.sv
// Board-level constants shared by the switch debouncer.
// The default stability window is derived from the board clock so that
// a clock change only needs to be made in one place.
package sw_debounce_pkg;

    localparam int BOARD_CLK_HZ          = 50_000_000;
    localparam int DEBOUNCE_MS           = 10;
    localparam int DEFAULT_STABLE_CYCLES = (BOARD_CLK_HZ / 1000) * DEBOUNCE_MS;
    localparam int DEFAULT_CNT_W         = 19;
    localparam int BOARD_SW_COUNT        = 8;

endpackage

// File: rtl/sw_debounce_bit.sv
// One switch line: two-flop synchroniser, stability counter, debounced bit
// and single-cycle rise/fall event flops.
// change_next is the combinational "an event fires on this edge" term.
// The top level registers the OR of these terms, so its summary pulse lines
// up with the per-bit pulses instead of trailing them by a cycle.
module sw_debounce_bit
    import sw_debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter int CNT_W         = DEFAULT_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic sw,
    output logic sw_db,
    output logic sw_rise,
    output logic sw_fall,
    output logic change_next
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;

    // Disagreement has lasted the full window, so the debounced bit flips on this edge.
    assign change_next = (s2 != sw_db) && (cnt == CNT_MAX);

    // Bring the asynchronous pin into the clock domain; only s2 is trusted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= sw;
            s2 <= s1;
        end
    end

    // Count consecutive disagreeing cycles; any agreement restarts the window.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            sw_db   <= 1'b0;
            sw_rise <= 1'b0;
            sw_fall <= 1'b0;
        end else begin
            sw_rise <= 1'b0;
            sw_fall <= 1'b0;
            if (s2 == sw_db) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                cnt     <= '0;
                sw_db   <= s2;
                sw_rise <= s2;
                sw_fall <= ~s2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sw_debounce.sv
// Switch input conditioner: one debounce slice per switch line plus a shared
// "something changed" pulse. sw_db feeds the switch peripheral directly,
// so software only ever sees clean, synchronised values.
module sw_debounce
    import sw_debounce_pkg::*;
#(
    parameter int WIDTH         = BOARD_SW_COUNT,
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter int CNT_W         = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw,
    output logic [WIDTH-1:0] sw_db,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             sw_changed
);

    logic [WIDTH-1:0] change_next;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        sw_debounce_bit #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .CNT_W         (CNT_W)
        ) u_bit (
            .clk         (clk),
            .rst         (rst),
            .sw          (sw[i]),
            .sw_db       (sw_db[i]),
            .sw_rise     (sw_rise[i]),
            .sw_fall     (sw_fall[i]),
            .change_next (change_next[i])
        );
    end

    // Register the OR of the per-bit event terms so it pulses alongside sw_rise/sw_fall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sw_changed <= 1'b0;
        end else begin
            sw_changed <= |change_next;
        end
    end

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce with a 4-cycle stability window.
// Inputs change and outputs are sampled on the falling clock edge.
// A step applied there reaches sw_db on the 6th following rising edge.
module tb_sw_debounce;

    logic       clk;
    logic       rst;
    logic [7:0] sw;
    logic [7:0] sw_db;
    logic [7:0] sw_rise;
    logic [7:0] sw_fall;
    logic       sw_changed;

    int checks;
    int passes;

    sw_debounce #(
        .WIDTH         (8),
        .STABLE_CYCLES (4),
        .CNT_W         (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sw         (sw),
        .sw_db      (sw_db),
        .sw_rise    (sw_rise),
        .sw_fall    (sw_fall),
        .sw_changed (sw_changed)
    );

    // Free-running 10-time-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic apply_stimulus(input logic [7:0] value);
        sw = value;
    endtask

    task automatic check_output(input string tag, input logic [7:0] observed,
                                input logic [7:0] expected);
        checks++;
        assert (observed === expected) begin
            passes++;
        end else begin
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic check_all(input string tag, input logic [7:0] db,
                             input logic [7:0] rise, input logic [7:0] fall,
                             input logic chg);
        check_output({tag, ".db"},   sw_db,   db);
        check_output({tag, ".rise"}, sw_rise, rise);
        check_output({tag, ".fall"}, sw_fall, fall);
        check_output({tag, ".chg"},  {7'b0, sw_changed}, {7'b0, chg});
    endtask

    // Linear directed sequence; every expected value is worked out by hand.
    initial begin
        checks = 0;
        passes = 0;
        rst = 1'b0;
        apply_stimulus(8'hFF);

        // Reset held with every switch on: outputs stay clear.
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check_all("reset_hold", 8'h00, 8'h00, 8'h00, 1'b0);
        end

        // Release: switches already on show up as rises on the 6th edge.
        rst = 1'b1;
        tick(5);
        check_all("rel_e5", 8'h00, 8'h00, 8'h00, 1'b0);
        tick(1);
        check_all("rel_e6", 8'hFF, 8'hFF, 8'h00, 1'b1);
        tick(1);
        check_all("rel_e7", 8'hFF, 8'h00, 8'h00, 1'b0);

        // Return to all-off.
        apply_stimulus(8'h00);
        tick(6);
        check_all("off_e6", 8'h00, 8'h00, 8'hFF, 1'b1);
        tick(3);
        check_all("off_settle", 8'h00, 8'h00, 8'h00, 1'b0);

        // Clean step up and down on bit 3.
        apply_stimulus(8'h08);
        tick(5);
        check_all("step_up_e5", 8'h00, 8'h00, 8'h00, 1'b0);
        tick(1);
        check_all("step_up_e6", 8'h08, 8'h08, 8'h00, 1'b1);
        tick(1);
        check_all("step_up_e7", 8'h08, 8'h00, 8'h00, 1'b0);
        apply_stimulus(8'h00);
        tick(5);
        check_all("step_dn_e5", 8'h08, 8'h00, 8'h00, 1'b0);
        tick(1);
        check_all("step_dn_e6", 8'h00, 8'h00, 8'h08, 1'b1);
        tick(1);
        check_all("step_dn_e7", 8'h00, 8'h00, 8'h00, 1'b0);
        tick(2);

        // Bounce on bit 0: high 3 / low 1, ten times, never accepted.
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(8'h01);
            tick(3);
            check_all("bounce_hi", 8'h00, 8'h00, 8'h00, 1'b0);
            apply_stimulus(8'h00);
            tick(1);
            check_all("bounce_lo", 8'h00, 8'h00, 8'h00, 1'b0);
        end
        apply_stimulus(8'h01);
        tick(5);
        check_all("bounce_hold_e5", 8'h00, 8'h00, 8'h00, 1'b0);
        tick(1);
        check_all("bounce_hold_e6", 8'h01, 8'h01, 8'h00, 1'b1);
        apply_stimulus(8'h00);
        tick(6);
        check_all("bounce_off_e6", 8'h00, 8'h00, 8'h01, 1'b1);
        tick(3);

        // Two bits rising on the same cycle give one shared pulse.
        apply_stimulus(8'h81);
        tick(5);
        check_all("simul_e5", 8'h00, 8'h00, 8'h00, 1'b0);
        tick(1);
        check_all("simul_e6", 8'h81, 8'h81, 8'h00, 1'b1);
        tick(1);
        check_all("simul_e7", 8'h81, 8'h00, 8'h00, 1'b0);
        apply_stimulus(8'h00);
        tick(6);
        check_all("simul_off", 8'h00, 8'h00, 8'h81, 1'b1);
        tick(3);

        // Bit 2 then bit 1 two cycles later: two separate pulses.
        apply_stimulus(8'h04);
        tick(2);
        apply_stimulus(8'h06);
        tick(4);
        check_all("stag_b2", 8'h04, 8'h04, 8'h00, 1'b1);
        tick(1);
        check_all("stag_gap", 8'h04, 8'h00, 8'h00, 1'b0);
        tick(1);
        check_all("stag_b1", 8'h06, 8'h02, 8'h00, 1'b1);
        tick(1);
        check_all("stag_end", 8'h06, 8'h00, 8'h00, 1'b0);
        apply_stimulus(8'h00);
        tick(6);
        check_all("stag_off", 8'h00, 8'h00, 8'h06, 1'b1);
        tick(3);

        // Reset asserted while bit 4 sits at count 3, one edge before acceptance.
        apply_stimulus(8'h10);
        tick(5);
        check_all("mid_pre", 8'h00, 8'h00, 8'h00, 1'b0);
        #2 rst = 1'b0;
        #1 check_all("mid_async", 8'h00, 8'h00, 8'h00, 1'b0);
        tick(1);
        check_all("mid_hold1", 8'h00, 8'h00, 8'h00, 1'b0);
        tick(1);
        check_all("mid_hold2", 8'h00, 8'h00, 8'h00, 1'b0);
        rst = 1'b1;
        tick(5);
        check_all("mid_rel_e5", 8'h00, 8'h00, 8'h00, 1'b0);
        tick(1);
        check_all("mid_rel_e6", 8'h10, 8'h10, 8'h00, 1'b1);
        tick(1);
        check_all("mid_rel_e7", 8'h10, 8'h00, 8'h00, 1'b0);
        apply_stimulus(8'h00);
        tick(6);
        check_all("mid_off", 8'h00, 8'h00, 8'h10, 1'b1);
        tick(3);

        // One-cycle glitch on every line is ignored.
        apply_stimulus(8'hFF);
        tick(1);
        apply_stimulus(8'h00);
        for (int i = 0; i < 8; i++) begin
            tick(1);
            check_all("glitch", 8'h00, 8'h00, 8'h00, 1'b0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
